pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_reg_chain.sv | 85 ++++++++
 tb/tb_pipe_reg_chain.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Elastic register chain with valid/ready handshake, bubble collapsing and flush.
// Each stage is a pipe_reg_stage; the advance chain runs combinationally from the output back to the input.
module pipe_reg_stage #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             adv,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_dat,
  output logic             v,
  output logic [WIDTH-1:0] dat
);
  // Data only moves when a valid word arrives, so bubbles never overwrite held data.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v   <= 1'b0;
      dat <= RST_VAL;
    end else if (flush) begin
      v <= 1'b0;
    end else if (adv) begin
      v <= in_v;
      if (in_v) dat <= in_dat;
    end
  end
endmodule

module pipe_reg_chain #(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            in_v;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic [DEPTH-1:0][WIDTH-1:0] in_dat;

  assign adv[DEPTH-1] = !v[DEPTH-1] | out_ready;
  assign in_ready     = adv[0] & !flush;
  assign in_v[0]      = in_valid & in_ready;
  assign in_dat[0]    = d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k < DEPTH-1) begin : g_adv
      assign adv[k] = !v[k] | adv[k+1];
    end
    if (k > 0) begin : g_link
      assign in_v[k]   = v[k-1];
      assign in_dat[k] = dat[k-1];
    end
    pipe_reg_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
      .clk    (clk),
      .clrn   (clrn),
      .flush  (flush),
      .adv    (adv[k]),
      .in_v   (in_v[k]),
      .in_dat (in_dat[k]),
      .v      (v[k]),
      .dat    (dat[k])
    );
  end

  assign q         = dat[DEPTH-1];
  assign out_valid = v[DEPTH-1];

  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) count = count + CW'(v[k]);
  end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain at WIDTH=8, DEPTH=2, RST_VAL=0.
module tb_pipe_reg_chain;
  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] d;
  logic       in_valid, in_ready, out_valid, out_ready, flush;
  logic [7:0] q;
  logic [1:0] count;
  int         n_tests = 0;
  int         n_fail  = 0;

  pipe_reg_chain #(.WIDTH(8), .DEPTH(2), .RST_VAL(8'h00)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clrn = 1'b0; d = 8'h00; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    flush = 1'b1; #1;
    chk("rst_flush_in_ready", 32'(in_ready), 0);
    flush = 1'b0;
    step();
    clrn = 1'b1;

    // streaming with out_ready high
    out_ready = 1'b1; in_valid = 1'b1; d = 8'h11; #1;
    chk("s_rdy0", 32'(in_ready), 1);
    step();
    chk("s_ov_c1", 32'(out_valid), 0);
    d = 8'h22; #1;
    chk("s_rdy1", 32'(in_ready), 1);
    step();
    chk("s_q_c2", 32'(q), 32'h11);
    chk("s_ov_c2", 32'(out_valid), 1);
    d = 8'h33; #1;
    chk("s_rdy2", 32'(in_ready), 1);
    step();
    chk("s_q_c3", 32'(q), 32'h22);
    in_valid = 1'b0;
    step();
    chk("s_q_c4", 32'(q), 32'h33);
    chk("s_ov_c4", 32'(out_valid), 1);
    step();
    chk("s_ov_c5", 32'(out_valid), 0);
    chk("s_cnt_c5", 32'(count), 0);

    // bubble collapse with output stalled
    out_ready = 1'b0; in_valid = 1'b1; d = 8'h55;
    step();
    in_valid = 1'b0;
    step();
    chk("b_ov", 32'(out_valid), 1);
    chk("b_q", 32'(q), 32'h55);
    chk("b_cnt1", 32'(count), 1);
    step(); step();
    in_valid = 1'b1; d = 8'h66; #1;
    chk("b_rdy", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("b_cnt2", 32'(count), 2);
    chk("b_q_hold", 32'(q), 32'h55);
    out_ready = 1'b1;
    step();
    chk("b_q66", 32'(q), 32'h66);
    step();
    chk("b_empty", 32'(count), 0);

    // backpressure, then simultaneous in/out when full
    out_ready = 1'b0; in_valid = 1'b1; d = 8'hA1;
    step();
    d = 8'hA2;
    step();
    d = 8'hA3; #1;
    chk("bp_cnt", 32'(count), 2);
    chk("bp_rdy0", 32'(in_ready), 0);
    step();
    chk("bp_q_hold", 32'(q), 32'hA1);
    chk("bp_cnt_hold", 32'(count), 2);
    out_ready = 1'b1; #1;
    chk("bp_rdy1", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("bp_q_a2", 32'(q), 32'hA2);
    chk("bp_cnt_full", 32'(count), 2);
    step();
    chk("bp_q_a3", 32'(q), 32'hA3);
    chk("bp_cnt1", 32'(count), 1);
    step();
    chk("bp_empty", 32'(out_valid), 0);

    // flush of a full chain
    out_ready = 1'b0; in_valid = 1'b1; d = 8'hA1;
    step();
    d = 8'hA2;
    step();
    flush = 1'b1; d = 8'h77; #1;
    chk("f_rdy", 32'(in_ready), 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("f_cnt", 32'(count), 0);
    chk("f_ov", 32'(out_valid), 0);
    chk("f_q_hold", 32'(q), 32'hA1);
    out_ready = 1'b1;
    step(); step();
    chk("f_no77_ov", 32'(out_valid), 0);
    chk("f_no77_q", 32'(q), 32'hA1);

    // full-rate throughput with chain full
    out_ready = 1'b0; in_valid = 1'b1; d = 8'hB1;
    step();
    d = 8'hB2;
    step();
    out_ready = 1'b1; d = 8'hC1; #1;
    chk("t_rdy", 32'(in_ready), 1);
    step();
    chk("t_q1", 32'(q), 32'hB2);
    chk("t_cnt1", 32'(count), 2);
    d = 8'hC2;
    step();
    chk("t_q2", 32'(q), 32'hC1);
    chk("t_cnt2", 32'(count), 2);
    d = 8'hC3;
    step();
    chk("t_q3", 32'(q), 32'hC2);
    d = 8'hC4;
    step();
    chk("t_q4", 32'(q), 32'hC3);
    chk("t_cnt4", 32'(count), 2);
    in_valid = 1'b0;
    step();
    chk("t_q5", 32'(q), 32'hC4);
    chk("t_cnt5", 32'(count), 1);
    step();

    // asynchronous reset between edges discards in-flight words
    out_ready = 1'b0; in_valid = 1'b1; d = 8'hA1;
    step();
    d = 8'hA2;
    step();
    in_valid = 1'b0;
    chk("r_pre_cnt", 32'(count), 2);
    clrn = 1'b0; #1;
    chk("r_ov", 32'(out_valid), 0);
    chk("r_q", 32'(q), 0);
    chk("r_cnt", 32'(count), 0);
    clrn = 1'b1;
    in_valid = 1'b1; d = 8'h99;
    step();
    in_valid = 1'b0;
    chk("r_post_ov1", 32'(out_valid), 0);
    step();
    chk("r_post_q", 32'(q), 32'h99);
    chk("r_post_cnt", 32'(count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
